vga_display_ctrl: RTL and testbench
===================================

Name: vga_display_ctrl

Overview:
- Display back-end on the Basys3. Generates 640x480@60 Hz VGA timing from the 100 MHz board clock.
- Issues pixel read addresses to the image ROM upstream, then takes the 4-bit-per-channel RGB that comes back through the grayscale/inversion filter stage.
- Aligns that RGB with delayed sync and blanking signals and drives the VGA connector pins through registers.
- Pixels outside the stored image window are shown black.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 4, board clocks per pixel (100 MHz / 4 = 25 MHz)
- IMG_W, 160, stored image width
- IMG_H, 120, stored image height
- ADDR_W, 15, image ROM address width
- PIPE_LAT, 2, pixel ticks from img_addr change to valid pix_r/g/b (1 = ROM, 1 = filter output register)

Ports:
- clk  in  1  100 MHz board clock
- rst_n  in  1  asynchronous, active-low reset
- pix_r  in  4  filtered red, valid PIPE_LAT ticks after its img_addr
- pix_g  in  4  filtered green
- pix_b  in  4  filtered blue
- img_addr  out  ADDR_W  image ROM read address
- pix_tick  out  1  one-clk pulse per pixel; upstream registers advance only on it
- frame_start  out  1  one-clk pulse at counter position (0,0)
- vga_hs  out  1  horizontal sync, active low
- vga_vs  out  1  vertical sync, active low
- vga_r  out  4  VGA red
- vga_g  out  4  VGA green
- vga_b  out  4  VGA blue

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rst_n). All flops clear immediately on rst_n=0.
- Reset values: div_cnt=0, h_cnt=0, v_cnt=0, img_addr=0, pix_tick=0, frame_start=0, vga_hs=1, vga_vs=1, vga_r/g/b=0. Delay-line stages: hs/vs stages=1, active/in_img stages=0.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_tick=1 for exactly the clk cycle where div_cnt==CLK_DIV-1. Period is CLK_DIV clocks.
- Counters advance only on pix_tick.
  - h_cnt counts 0..H_TOTAL-1 (H_TOTAL=800), then returns to 0.
  - v_cnt increments when h_cnt wraps, counts 0..V_TOTAL-1 (V_TOTAL=525), then returns to 0. Both wrap on the same tick at (799,524).
- Raw (stage-0) signals, combinational from the counters:
  - hs0 = 0 for h_cnt in [656,751], else 1
  - vs0 = 0 for v_cnt in [490,491], else 1
  - act0 = h_cnt<640 && v_cnt<480
  - img0 = h_cnt<IMG_W && v_cnt<IMG_H
- img_addr: registered on pix_tick. Equals v_cnt*IMG_W + h_cnt when img0=1, else holds 0. Multiply is by a constant; width is ADDR_W; no overflow since the maximum is 19199.
- Alignment: hs, vs, act and img pass through PIPE_LAT-stage shift registers that shift on pix_tick.
- Output register, loaded on pix_tick:
  - vga_hs and vga_vs take the last delay stage.
  - vga_r/g/b = pix_r/g/b when act_d && img_d, else 4'h0.
- End-to-end: the counter position that generated img_addr reaches the pins PIPE_LAT+1 ticks later, and sync and RGB move together.
- frame_start: a one-clk pulse in the pix_tick cycle where h_cnt==0 && v_cnt==0 (undelayed counter position).
- rst_n asserted mid-frame: outputs go to their reset values within the same cycle, with no sync glitch to 0. After release, timing restarts at (0,0) with a fresh frame.
- Pixel data is never used during blanking, even if a stale ROM value is still present.

Decomposition:
- Shared package vga_pkg holds the timing constants (H_ACTIVE..V_BP, H_TOTAL, V_TOTAL, sync start/end positions) and IMG_W/IMG_H/ADDR_W.
- One natural sub-module, vga_timing_gen: divider, h/v counters, hs0/vs0/act0/img0, frame_start.
- The top-level vga_display_ctrl adds the address generation, delay lines and output register.

Test Plan:
- Reset release, 4 full frames -> pix_tick period is 4 clocks. Each vga_hs low pulse is 96 ticks (384 clocks) and hsync period is 800 ticks. Each vga_vs low pulse is 2 lines (1600 ticks) and frame is 420,000 ticks. frame_start fires once per frame.
- Behavioural ROM returning pix = {addr[3:0], addr[7:4], addr[11:8]} with 2-tick latency -> at visible pixel (x=5, y=2), vga_r/g/b = decode of 325. Value appears exactly 3 ticks after img_addr=325.
- Position x=160..639 or y=120..479, and all blanking -> vga_r/g/b = 0 regardless of pix_r/g/b (drive 4'hF).
- Last image pixel (159,119) -> img_addr=19199. The next tick gives img_addr=0. vga_hs/vga_vs stay 1 through the active region.
- rst_n pulled low at h_cnt=700, v_cnt=300 (mid-sync window) -> same cycle: vga_hs=1, vga_vs=1, rgb=0. After release, the first frame_start occurs on the first pix_tick.
- Counter wrap at (799,524) -> the next tick gives (0,0) and frame_start. No extra line or pixel is inserted.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and image window geometry for the display back-end.
package vga_pkg;

    // 640x480@60 Hz horizontal timing, in pixels
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;

    // Vertical timing, in lines
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

    // Pixel clock divider and upstream pipeline depth
    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned PIPE_LAT = 2;

    // Stored image window and ROM addressing
    localparam int unsigned IMG_W    = 160;
    localparam int unsigned IMG_H    = 120;
    localparam int unsigned ADDR_W   = 15;

    // Datapath widths
    localparam int unsigned H_CNT_W  = 10;
    localparam int unsigned V_CNT_W  = 10;
    localparam int unsigned RGB_W    = 4;

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-clock divider, h/v raster counters and raw (undelayed) sync/window flags.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CFG_H_ACTIVE = H_ACTIVE,
    parameter int unsigned CFG_H_FP     = H_FP,
    parameter int unsigned CFG_H_SYNC   = H_SYNC,
    parameter int unsigned CFG_H_BP     = H_BP,
    parameter int unsigned CFG_V_ACTIVE = V_ACTIVE,
    parameter int unsigned CFG_V_FP     = V_FP,
    parameter int unsigned CFG_V_SYNC   = V_SYNC,
    parameter int unsigned CFG_V_BP     = V_BP,
    parameter int unsigned CFG_CLK_DIV  = CLK_DIV,
    parameter int unsigned CFG_IMG_W    = IMG_W,
    parameter int unsigned CFG_IMG_H    = IMG_H
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               pix_tick,
    output logic               frame_start,
    output logic [H_CNT_W-1:0] h_cnt,
    output logic [V_CNT_W-1:0] v_cnt,
    output logic               hs0_c,
    output logic               vs0_c,
    output logic               act0_c,
    output logic               img0_c
);

    localparam int unsigned H_TOT   = CFG_H_ACTIVE + CFG_H_FP + CFG_H_SYNC + CFG_H_BP;
    localparam int unsigned V_TOT   = CFG_V_ACTIVE + CFG_V_FP + CFG_V_SYNC + CFG_V_BP;
    localparam int unsigned HS_BEG  = CFG_H_ACTIVE + CFG_H_FP;
    localparam int unsigned HS_LAST = HS_BEG + CFG_H_SYNC - 1;
    localparam int unsigned VS_BEG  = CFG_V_ACTIVE + CFG_V_FP;
    localparam int unsigned VS_LAST = VS_BEG + CFG_V_SYNC - 1;
    localparam int unsigned DIV_W   = $clog2(CFG_CLK_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic             pre_tick;
    logic             div_last;

    // pix_tick is registered, so it is loaded one cycle ahead of div_cnt reaching its last value
    assign pre_tick = (div_cnt == DIV_W'(CFG_CLK_DIV - 2));
    assign div_last = (div_cnt == DIV_W'(CFG_CLK_DIV - 1));

    // Clock divider producing the one-clk pixel strobe and the frame marker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            pix_tick    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= div_last ? '0 : div_cnt + 1'b1;
            pix_tick    <= pre_tick;
            frame_start <= pre_tick && (h_cnt == '0) && (v_cnt == '0);
        end
    end

    // Raster counters, advancing once per pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_tick) begin
            if (h_cnt == H_CNT_W'(H_TOT - 1)) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_CNT_W'(V_TOT - 1)) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Stage-0 sync, visible-area and image-window flags decoded from the counters
    always_comb begin
        hs0_c  = !((h_cnt >= H_CNT_W'(HS_BEG)) && (h_cnt <= H_CNT_W'(HS_LAST)));
        vs0_c  = !((v_cnt >= V_CNT_W'(VS_BEG)) && (v_cnt <= V_CNT_W'(VS_LAST)));
        act0_c = (h_cnt < H_CNT_W'(CFG_H_ACTIVE)) && (v_cnt < V_CNT_W'(CFG_V_ACTIVE));
        img0_c = (h_cnt < H_CNT_W'(CFG_IMG_W)) && (v_cnt < V_CNT_W'(CFG_IMG_H));
    end

endmodule

// File: rtl/vga_display_ctrl.sv
// VGA back-end: ROM address generation, sync/RGB alignment and registered pin drivers.
module vga_display_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned CFG_H_ACTIVE = H_ACTIVE,
    parameter int unsigned CFG_H_FP     = H_FP,
    parameter int unsigned CFG_H_SYNC   = H_SYNC,
    parameter int unsigned CFG_H_BP     = H_BP,
    parameter int unsigned CFG_V_ACTIVE = V_ACTIVE,
    parameter int unsigned CFG_V_FP     = V_FP,
    parameter int unsigned CFG_V_SYNC   = V_SYNC,
    parameter int unsigned CFG_V_BP     = V_BP,
    parameter int unsigned CFG_CLK_DIV  = CLK_DIV,
    parameter int unsigned CFG_IMG_W    = IMG_W,
    parameter int unsigned CFG_IMG_H    = IMG_H,
    parameter int unsigned CFG_ADDR_W   = ADDR_W,
    parameter int unsigned CFG_PIPE_LAT = PIPE_LAT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [RGB_W-1:0]      pix_r,
    input  logic [RGB_W-1:0]      pix_g,
    input  logic [RGB_W-1:0]      pix_b,
    output logic [CFG_ADDR_W-1:0] img_addr,
    output logic                  pix_tick,
    output logic                  frame_start,
    output logic                  vga_hs,
    output logic                  vga_vs,
    output logic [RGB_W-1:0]      vga_r,
    output logic [RGB_W-1:0]      vga_g,
    output logic [RGB_W-1:0]      vga_b
);

    // One stage runs alongside the img_addr register, the rest cover the upstream ROM/filter latency
    localparam int unsigned DLY = CFG_PIPE_LAT + 1;

    logic [H_CNT_W-1:0]    h_cnt;
    logic [V_CNT_W-1:0]    v_cnt;
    logic                  hs0;
    logic                  vs0;
    logic                  act0;
    logic                  img0;
    logic [CFG_ADDR_W-1:0] addr_c;
    logic [DLY-1:0]        hs_d;
    logic [DLY-1:0]        vs_d;
    logic [DLY-1:0]        act_d;
    logic [DLY-1:0]        img_d;
    logic                  show;

    vga_timing_gen #(
        .CFG_H_ACTIVE (CFG_H_ACTIVE),
        .CFG_H_FP     (CFG_H_FP),
        .CFG_H_SYNC   (CFG_H_SYNC),
        .CFG_H_BP     (CFG_H_BP),
        .CFG_V_ACTIVE (CFG_V_ACTIVE),
        .CFG_V_FP     (CFG_V_FP),
        .CFG_V_SYNC   (CFG_V_SYNC),
        .CFG_V_BP     (CFG_V_BP),
        .CFG_CLK_DIV  (CFG_CLK_DIV),
        .CFG_IMG_W    (CFG_IMG_W),
        .CFG_IMG_H    (CFG_IMG_H)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_tick    (pix_tick),
        .frame_start (frame_start),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .hs0_c       (hs0),
        .vs0_c       (vs0),
        .act0_c      (act0),
        .img0_c      (img0)
    );

    // Linear image address inside the window, parked at 0 outside it
    always_comb begin
        addr_c = '0;
        if (img0) begin
            addr_c = CFG_ADDR_W'(32'(v_cnt) * CFG_IMG_W + 32'(h_cnt));
        end
    end

    // Address register and sync/window delay lines, all advancing on the pixel strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img_addr <= '0;
            hs_d     <= '1;
            vs_d     <= '1;
            act_d    <= '0;
            img_d    <= '0;
        end else if (pix_tick) begin
            img_addr <= addr_c;
            hs_d     <= {hs_d[DLY-2:0], hs0};
            vs_d     <= {vs_d[DLY-2:0], vs0};
            act_d    <= {act_d[DLY-2:0], act0};
            img_d    <= {img_d[DLY-2:0], img0};
        end
    end

    // Upstream pixel data is only trusted inside both the visible area and the image window
    assign show = act_d[DLY-1] && img_d[DLY-1];

    // Pin drivers: sync and RGB leave together from one register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
        end else if (pix_tick) begin
            vga_hs <= hs_d[DLY-1];
            vga_vs <= vs_d[DLY-1];
            vga_r  <= show ? pix_r : '0;
            vga_g  <= show ? pix_g : '0;
            vga_b  <= show ? pix_b : '0;
        end
    end

endmodule

// File: tb/tb_vga_display_ctrl.sv
// Directed bench: a full-size instance for line-level timing and a reduced-raster
// instance for frame-level behaviour, each fed by a 2-tick behavioural ROM/filter.
module tb_vga_display_ctrl;

    logic clk;
    logic rst_n;

    // Full-size instance signals
    logic [14:0] addr_f;
    logic        tick_f, fs_f, hs_f, vs_f;
    logic [3:0]  r_f, g_f, b_f, pr_f, pg_f, pb_f;
    logic [14:0] rom_q_f = '0;
    logic [11:0] pix_q_f = '0;
    logic        force_f = 1'b0;

    // Reduced-raster instance signals
    logic [14:0] addr_s;
    logic        tick_s, fs_s, hs_s, vs_s;
    logic [3:0]  r_s, g_s, b_s, pr_s, pg_s, pb_s;
    logic [14:0] rom_q_s = '0;
    logic [11:0] pix_q_s = '0;
    logic        force_s = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int tf      = 0;
    int ts      = 0;
    int clks    = 0;

    vga_display_ctrl u_full (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_r       (pr_f),
        .pix_g       (pg_f),
        .pix_b       (pb_f),
        .img_addr    (addr_f),
        .pix_tick    (tick_f),
        .frame_start (fs_f),
        .vga_hs      (hs_f),
        .vga_vs      (vs_f),
        .vga_r       (r_f),
        .vga_g       (g_f),
        .vga_b       (b_f)
    );

    // 28 x 17 raster, 8 x 5 image, hsync at x 22..24, vsync on lines 13..14
    vga_display_ctrl #(
        .CFG_H_ACTIVE (20),
        .CFG_H_FP     (2),
        .CFG_H_SYNC   (3),
        .CFG_H_BP     (3),
        .CFG_V_ACTIVE (12),
        .CFG_V_FP     (1),
        .CFG_V_SYNC   (2),
        .CFG_V_BP     (2),
        .CFG_IMG_W    (8),
        .CFG_IMG_H    (5)
    ) u_small (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_r       (pr_s),
        .pix_g       (pg_s),
        .pix_b       (pb_s),
        .img_addr    (addr_s),
        .pix_tick    (tick_s),
        .frame_start (fs_s),
        .vga_hs      (hs_s),
        .vga_vs      (vs_s),
        .vga_r       (r_s),
        .vga_g       (g_s),
        .vga_b       (b_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ROM + filter register: pix = {addr[3:0], addr[7:4], addr[11:8]} as r/g/b
    always @(posedge clk) begin
        if (tick_f) begin
            rom_q_f <= addr_f;
            pix_q_f <= {rom_q_f[11:8], rom_q_f[7:4], rom_q_f[3:0]};
        end
        if (tick_s) begin
            rom_q_s <= addr_s;
            pix_q_s <= {rom_q_s[11:8], rom_q_s[7:4], rom_q_s[3:0]};
        end
    end

    assign pr_f = force_f ? 4'hF : pix_q_f[3:0];
    assign pg_f = force_f ? 4'hF : pix_q_f[7:4];
    assign pb_f = force_f ? 4'hF : pix_q_f[11:8];
    assign pr_s = force_s ? 4'hF : pix_q_s[3:0];
    assign pg_s = force_s ? 4'hF : pix_q_s[7:4];
    assign pb_s = force_s ? 4'hF : pix_q_s[11:8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to the negedge inside the next pix_tick cycle of the selected instance
    task automatic next_tick(input bit sel, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((sel ? tick_s : tick_f) == 1'b0) && (n < 8));
        if ((sel ? tick_s : tick_f) == 1'b0) check("tick_timeout", 32'(n), 32'(4));
        if (sel) ts++; else tf++;
    endtask

    task automatic goto_tick(input bit sel, input int t);
        int n;
        while ((sel ? ts : tf) < t) next_tick(sel, n);
    endtask

    function automatic logic [31:0] rgb_f();
        return 32'({r_f, g_f, b_f});
    endfunction

    function automatic logic [31:0] rgb_s();
        return 32'({r_s, g_s, b_s});
    endfunction

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_sync_f", 32'({hs_f, vs_f}), 32'h3);
        check("rst_rgb_f", rgb_f(), 32'h0);
        check("rst_misc_f", 32'({addr_f, tick_f, fs_f}), 32'h0);
        check("rst_sync_s", 32'({hs_s, vs_s}), 32'h3);

        // Full-size instance: first tick latency, period, frame_start on the first tick
        rst_n = 1'b1;
        tf = -1;
        next_tick(1'b0, clks);
        check("first_tick_clks", 32'(clks), 32'd3);
        check("fs_first_tick", 32'(fs_f), 32'd1);
        next_tick(1'b0, clks);
        check("tick_period", 32'(clks), 32'd4);
        check("fs_one_tick", 32'(fs_f), 32'd0);

        // (5,2) -> address 325, appearing at the pins three ticks later
        while ((addr_f != 15'd325) && (tf < 2000)) next_tick(1'b0, clks);
        check("addr325_tick", 32'(tf), 32'd1606);
        goto_tick(1'b0, 1608);
        check("rgb_324", rgb_f(), 32'h441);
        goto_tick(1'b0, 1609);
        check("rgb_325", rgb_f(), 32'h541);

        // Drive full-scale pixels; only the image window may pass them
        force_f = 1'b1;
        goto_tick(1'b0, 1704);
        check("img_x100", rgb_f(), 32'hFFF);
        check("hs_active", 32'({hs_f, vs_f}), 32'h3);
        goto_tick(1'b0, 1760);
        check("addr_last_x", 32'(addr_f), 32'd479);
        goto_tick(1'b0, 1761);
        check("addr_out_win", 32'(addr_f), 32'd0);
        goto_tick(1'b0, 1763);
        check("img_x159", rgb_f(), 32'hFFF);
        goto_tick(1'b0, 1764);
        check("blank_x160", rgb_f(), 32'h0);
        goto_tick(1'b0, 2243);
        check("blank_x639", rgb_f(), 32'h0);
        goto_tick(1'b0, 2259);
        check("hs_x655", 32'(hs_f), 32'd1);
        goto_tick(1'b0, 2260);
        check("hs_x656", 32'(hs_f), 32'd0);
        check("blank_hsync", rgb_f(), 32'h0);
        goto_tick(1'b0, 2355);
        check("hs_x751", 32'(hs_f), 32'd0);
        goto_tick(1'b0, 2356);
        check("hs_x752", 32'(hs_f), 32'd1);
        goto_tick(1'b0, 3059);
        check("hs_l3_x655", 32'(hs_f), 32'd1);
        goto_tick(1'b0, 3060);
        check("hs_l3_x656", 32'({hs_f, vs_f}), 32'h1);

        // Reduced-raster instance: fresh start
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ts = -1;
        next_tick(1'b1, clks);
        check("s_first_tick_clks", 32'(clks), 32'd3);
        check("s_fs_t0", 32'(fs_s), 32'd1);
        goto_tick(1'b1, 1);
        check("s_fs_t1", 32'(fs_s), 32'd0);
        goto_tick(1'b1, 64);
        check("s_rgb_20", rgb_s(), 32'h410);
        goto_tick(1'b1, 65);
        check("s_rgb_21", rgb_s(), 32'h510);
        goto_tick(1'b1, 98);
        check("s_sync_active", 32'({hs_s, vs_s}), 32'h3);
        goto_tick(1'b1, 120);
        check("s_addr_last", 32'(addr_s), 32'd39);
        goto_tick(1'b1, 121);
        check("s_addr_after", 32'(addr_s), 32'd0);
        goto_tick(1'b1, 367);
        check("s_vs_l12", 32'(vs_s), 32'd1);
        goto_tick(1'b1, 368);
        check("s_vs_l13", 32'(vs_s), 32'd0);
        goto_tick(1'b1, 423);
        check("s_vs_l14", 32'(vs_s), 32'd0);
        goto_tick(1'b1, 424);
        check("s_vs_l15", 32'(vs_s), 32'd1);
        goto_tick(1'b1, 475);
        check("s_fs_pre_wrap", 32'(fs_s), 32'd0);
        goto_tick(1'b1, 476);
        check("s_fs_wrap", 32'(fs_s), 32'd1);
        check("s_addr_wrap", 32'(addr_s), 32'd0);
        goto_tick(1'b1, 478);
        check("s_addr_f2_x1", 32'(addr_s), 32'd1);
        goto_tick(1'b1, 951);
        check("s_fs_pre_f3", 32'(fs_s), 32'd0);
        goto_tick(1'b1, 952);
        check("s_fs_f3", 32'(fs_s), 32'd1);
        goto_tick(1'b1, 1428);
        check("s_fs_f4", 32'(fs_s), 32'd1);

        // Full-scale pixel input: only (x<8, y<5) may show it
        force_s = 1'b1;
        goto_tick(1'b1, 1463);
        check("s_img_3_1", rgb_s(), 32'hFFF);
        goto_tick(1'b1, 1468);
        check("s_blank_8_1", rgb_s(), 32'h0);
        goto_tick(1'b1, 1513);
        check("s_blank_hblank", rgb_s(), 32'h0);
        goto_tick(1'b1, 1602);
        check("s_blank_2_6", rgb_s(), 32'h0);
        goto_tick(1'b1, 1855);
        check("s_blank_vblank", rgb_s(), 32'h0);

        // Reset while the pins are inside an hsync pulse
        goto_tick(1'b1, 2099);
        check("s_hs_pre_rst", 32'(hs_s), 32'd0);
        rst_n = 1'b0;
        #1;
        check("s_rst_sync", 32'({hs_s, vs_s}), 32'h3);
        check("s_rst_rgb", rgb_s(), 32'h0);
        check("s_rst_addr", 32'(addr_s), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ts = -1;
        next_tick(1'b1, clks);
        check("s_rel_tick_clks", 32'(clks), 32'd3);
        check("s_rel_fs", 32'(fs_s), 32'd1);
        goto_tick(1'b1, 2);
        check("s_rel_addr_x1", 32'(addr_s), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
